// File: rtl/fact_pkg.sv
// Shared constants and types for the factorial datapath slice.
package fact_pkg;

    localparam int FACT_N_W   = 4;
    localparam int FACT_ACC_W = 32;

    // Sequential multiplier control states.
    typedef enum logic [1:0] {
        M_IDLE,
        M_RUN,
        M_DONE
    } mult_state_t;

endpackage

// File: rtl/seq_mult.sv
// Shift-add multiplier: one partial product per cycle over the N_W bits of b,
// LSB first. The final partial sum is exposed combinationally together with
// the done strobe, so the caller can commit the product on the closing edge
// of the last RUN cycle. DONE is the one-cycle turnaround after that commit.
module seq_mult
    import fact_pkg::*;
#(
    parameter int N_W   = FACT_N_W,
    parameter int ACC_W = FACT_ACC_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   abort,
    input  logic [ACC_W-1:0]       a,
    input  logic [N_W-1:0]         b,
    output logic                   busy,
    output logic                   done,
    output logic [ACC_W+N_W-1:0]   p
);

    localparam int P_W   = ACC_W + N_W;
    localparam int CNT_W = (N_W > 1) ? $clog2(N_W) : 1;

    mult_state_t        state_reg;
    mult_state_t        state_next;
    logic [P_W-1:0]     mcand_reg;
    logic [N_W-1:0]     mplier_reg;
    logic [P_W-1:0]     prod_reg;
    logic [CNT_W-1:0]   bit_cnt_reg;
    logic [P_W-1:0]     partial;
    logic               last_bit;
    logic               can_start;

    assign last_bit  = (bit_cnt_reg == CNT_W'(N_W - 1));
    assign partial   = prod_reg + (mplier_reg[0] ? mcand_reg : '0);
    assign busy      = (state_reg == M_RUN);
    assign done      = (state_reg == M_RUN) && last_bit;
    assign p         = partial;
    // A new start is honoured whenever the engine is not mid-run.
    assign can_start = start && (state_reg != M_RUN);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= M_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; abort always wins and returns to IDLE.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            M_IDLE:  if (start)    state_next = M_RUN;
            M_RUN:   if (last_bit) state_next = M_DONE;
            M_DONE:  state_next = start ? M_RUN : M_IDLE;
            default: state_next = M_IDLE;
        endcase
        if (abort) begin
            state_next = M_IDLE;
        end
    end

    // Operand capture on start, then one shift-add per RUN cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mcand_reg   <= '0;
            mplier_reg  <= '0;
            prod_reg    <= '0;
            bit_cnt_reg <= '0;
        end else if (can_start && !abort) begin
            mcand_reg   <= {{N_W{1'b0}}, a};
            mplier_reg  <= b;
            prod_reg    <= '0;
            bit_cnt_reg <= '0;
        end else if (state_reg == M_RUN) begin
            prod_reg    <= partial;
            mcand_reg   <= mcand_reg << 1;
            mplier_reg  <= mplier_reg >> 1;
            bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
        end
    end

endmodule

// File: rtl/fact_datapath.sv
// Factorial datapath: holds n, the iteration counter and the running product.
// Each accepted step multiplies acc by (cnt+1) through seq_mult and advances
// cnt; a_ne_b tells the controlling FSM whether more iterations remain.
module fact_datapath
    import fact_pkg::*;
#(
    parameter int N_W   = FACT_N_W,
    parameter int ACC_W = FACT_ACC_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ld,
    input  logic               step,
    input  logic [N_W-1:0]     n_in,
    output logic               a_ne_b,
    output logic               busy,
    output logic               step_done,
    output logic [ACC_W-1:0]   acc,
    output logic               ovf
);

    localparam int P_W = ACC_W + N_W;

    logic [N_W-1:0]   n_reg, n_next;
    logic [N_W-1:0]   cnt_reg, cnt_next;
    logic [ACC_W-1:0] acc_reg, acc_next;
    logic             ovf_reg, ovf_next;
    logic             a_ne_b_reg;
    logic             step_done_reg;

    logic             mult_busy;
    logic             mult_done;
    logic [P_W-1:0]   mult_p;
    logic             step_ok;
    logic             commit;
    logic [N_W-1:0]   n_load;
    logic [N_W-1:0]   cnt_inc;

    // ld has priority: it blocks new steps and cancels any pending commit.
    assign step_ok = step && !ld && !mult_busy && a_ne_b_reg;
    assign commit  = mult_done && !ld;
    assign n_load  = (n_in == '0) ? N_W'(1) : n_in;
    assign cnt_inc = cnt_reg + N_W'(1);

    seq_mult #(
        .N_W   (N_W),
        .ACC_W (ACC_W)
    ) u_mult (
        .clk   (clk),
        .rst   (rst),
        .start (step_ok),
        .abort (ld),
        .a     (acc_reg),
        .b     (cnt_inc),
        .busy  (mult_busy),
        .done  (mult_done),
        .p     (mult_p)
    );

    // Next values for the operand, counter, product and overflow flag.
    always_comb begin
        n_next   = n_reg;
        cnt_next = cnt_reg;
        acc_next = acc_reg;
        ovf_next = ovf_reg;
        if (ld) begin
            n_next   = n_load;
            cnt_next = N_W'(1);
            acc_next = ACC_W'(1);
            ovf_next = 1'b0;
        end else if (commit) begin
            cnt_next = cnt_inc;
            acc_next = mult_p[ACC_W-1:0];
            ovf_next = ovf_reg | (|mult_p[P_W-1:ACC_W]);
        end
    end

    // State registers; a_ne_b is computed from the next values so it tracks
    // the counter from the cycle after each load or commit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            n_reg         <= '0;
            cnt_reg       <= '0;
            acc_reg       <= '0;
            ovf_reg       <= 1'b0;
            a_ne_b_reg    <= 1'b0;
            step_done_reg <= 1'b0;
        end else begin
            n_reg         <= n_next;
            cnt_reg       <= cnt_next;
            acc_reg       <= acc_next;
            ovf_reg       <= ovf_next;
            a_ne_b_reg    <= (cnt_next != n_next);
            step_done_reg <= commit;
        end
    end

    assign a_ne_b    = a_ne_b_reg;
    assign busy      = mult_busy;
    assign step_done = step_done_reg;
    assign acc       = acc_reg;
    assign ovf       = ovf_reg;

endmodule
